// File: rtl/fadd_arbiter_if.sv
// Bundle between the FPU issue paths, the shared fadd and the fadd arbiter.
// The arbiter sits on the slave modport; requesters and the fadd sit on the master side.
interface fadd_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [32*NREQ-1:0]   req_x1;
    logic [32*NREQ-1:0]   req_x2;
    logic [NREQ-1:0]      req_sub;
    logic [31:0]          fa_x1;
    logic [31:0]          fa_x2;
    logic [31:0]          fa_y;
    logic                 fa_ovf;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic [32*NREQ-1:0]   rsp_y;
    logic [NREQ-1:0]      rsp_ovf;
    logic                 busy;

    modport slave (
        input  req_valid, req_x1, req_x2, req_sub, fa_y, fa_ovf, rsp_ready,
        output req_ready, fa_x1, fa_x2, rsp_valid, rsp_y, rsp_ovf, busy
    );

    modport master (
        output req_valid, req_x1, req_x2, req_sub, fa_y, fa_ovf, rsp_ready,
        input  req_ready, fa_x1, fa_x2, rsp_valid, rsp_y, rsp_ovf, busy
    );
endinterface

// File: rtl/fadd_arbiter.sv
// Round-robin share of one fadd among NREQ requesters; one issue per cycle, fsub via x2 sign flip.
// Each result lands in a per-requester register held until rsp_ready; one op outstanding per requester.
module fadd_arbiter #(
    parameter int NREQ    = 2,
    parameter int LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst,
    fadd_arbiter_if.slave   bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDW-1:0]     ptr;
    logic [NREQ-1:0]    pend;
    logic [NREQ-1:0]    eligible;
    logic [NREQ-1:0]    grant;
    logic [IDW-1:0]     gid;
    logic               found;
    logic [31:0]        sel_x1;
    logic [31:0]        sel_x2;
    int                 j;

    logic [31:0]        fa_x1_q;
    logic [31:0]        fa_x2_q;
    logic [LATENCY-1:0] pipe_vld;
    logic [IDW-1:0]     pipe_id [LATENCY];
    logic               ret_vld;
    logic [IDW-1:0]     ret_id;

    logic [NREQ-1:0]    rsp_valid_q;
    logic [32*NREQ-1:0] rsp_y_q;
    logic [NREQ-1:0]    rsp_ovf_q;

    assign eligible = bus.req_valid & ~pend;

    // Search starts at ptr and wraps; the first eligible requester wins and its operands are muxed out.
    always_comb begin
        grant  = '0;
        gid    = '0;
        found  = 1'b0;
        sel_x1 = '0;
        sel_x2 = '0;
        j      = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && eligible[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                gid      = IDW'(j);
                sel_x1   = bus.req_x1[32*j +: 32];
                sel_x2   = {bus.req_x2[32*j+31] ^ bus.req_sub[j], bus.req_x2[32*j +: 31]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= '0;
            pend    <= '0;
            fa_x1_q <= '0;
            fa_x2_q <= '0;
        end else begin
            pend <= (pend & ~(rsp_valid_q & bus.rsp_ready)) | grant;
            if (found) begin
                ptr     <= (int'(gid) == NREQ - 1) ? '0 : gid + 1'b1;
                fa_x1_q <= sel_x1;
                fa_x2_q <= sel_x2;
            end
        end
    end

    // Owner-id delay line matching the external fadd latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld <= '0;
            for (int s = 0; s < LATENCY; s++) pipe_id[s] <= '0;
        end else begin
            pipe_vld[0] <= found;
            pipe_id[0]  <= gid;
            for (int s = 1; s < LATENCY; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                pipe_id[s]  <= pipe_id[s-1];
            end
        end
    end

    assign ret_vld = pipe_vld[LATENCY-1];
    assign ret_id  = pipe_id[LATENCY-1];

    // A returning owner always has rsp_valid low (pend blocks re-issue), so capture never collides with a held result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= '0;
            rsp_y_q     <= '0;
            rsp_ovf_q   <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (rsp_valid_q[i] && bus.rsp_ready[i]) rsp_valid_q[i] <= 1'b0;
                if (ret_vld && int'(ret_id) == i) begin
                    rsp_valid_q[i]       <= 1'b1;
                    rsp_y_q[32*i +: 32]  <= bus.fa_y;
                    rsp_ovf_q[i]         <= bus.fa_ovf;
                end
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.fa_x1     = fa_x1_q;
    assign bus.fa_x2     = fa_x2_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.rsp_ovf   = rsp_ovf_q;
    assign bus.busy      = |pend;
endmodule

// File: tb/tb_fadd_arbiter.sv
// Bench for fadd_arbiter: two instances (LATENCY 1 and 3) share stimulus, each checked every cycle against a transaction-level model.
module tb_fadd_arbiter;
    localparam int NREQ = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fadd_arbiter_if #(.NREQ(NREQ)) ifa ();
    fadd_arbiter_if #(.NREQ(NREQ)) ifb ();

    fadd_arbiter #(.NREQ(NREQ), .LATENCY(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    fadd_arbiter #(.NREQ(NREQ), .LATENCY(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    logic [NREQ-1:0]    d_valid, d_sub, d_ready;
    logic [32*NREQ-1:0] d_x1, d_x2;

    assign ifa.req_valid = d_valid;  assign ifb.req_valid = d_valid;
    assign ifa.req_sub   = d_sub;    assign ifb.req_sub   = d_sub;
    assign ifa.req_x1    = d_x1;     assign ifb.req_x1    = d_x1;
    assign ifa.req_x2    = d_x2;     assign ifb.req_x2    = d_x2;
    assign ifa.rsp_ready = d_ready;  assign ifb.rsp_ready = d_ready;

    // Stand-in fadd: known IEEE cases from a table, any other pair gets an arbitrary deterministic mix.
    function automatic logic [32:0] fadd_model(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F800000 && b == 32'h40000000) return {1'b0, 32'h40400000};
        if (a == 32'h40400000 && b == 32'hBF800000) return {1'b0, 32'h40000000};
        if (a == 32'h7F7FFFFF && b == 32'h7F7FFFFF) return {1'b1, 32'h7F800000};
        if (a == 32'h7F800000 && b == 32'hFFC00000) return {1'b0, 32'h7FC00000};
        return {^(a & b), a + {b[15:0], b[31:16]}};
    endfunction

    assign {ifa.fa_ovf, ifa.fa_y} = fadd_model(ifa.fa_x1, ifa.fa_x2);
    logic [32:0] b_s0 = '0;
    logic [32:0] b_s1 = '0;
    always @(posedge clk) begin
        b_s0 <= fadd_model(ifb.fa_x1, ifb.fa_x2);
        b_s1 <= b_s0;
    end
    assign {ifb.fa_ovf, ifb.fa_y} = b_s1;

    logic [NREQ-1:0]    o_ready[2], o_rv[2], o_ro[2];
    logic [32*NREQ-1:0] o_ry[2];
    logic [31:0]        o_fx1[2], o_fx2[2];
    logic               o_busy[2];
    assign o_ready[0] = ifa.req_ready;  assign o_ready[1] = ifb.req_ready;
    assign o_rv[0]    = ifa.rsp_valid;  assign o_rv[1]    = ifb.rsp_valid;
    assign o_ro[0]    = ifa.rsp_ovf;    assign o_ro[1]    = ifb.rsp_ovf;
    assign o_ry[0]    = ifa.rsp_y;      assign o_ry[1]    = ifb.rsp_y;
    assign o_fx1[0]   = ifa.fa_x1;      assign o_fx1[1]   = ifb.fa_x1;
    assign o_fx2[0]   = ifa.fa_x2;      assign o_fx2[1]   = ifb.fa_x2;
    assign o_busy[0]  = ifa.busy;       assign o_busy[1]  = ifb.busy;

    // Reference model: grant rule, pending set, result registers and a queue of in-flight ops with countdowns.
    typedef struct {
        int          inst;
        int          owner;
        int          cnt;
        logic [31:0] y;
        logic        ovf;
    } item_t;

    item_t              q[$];
    int                 lat[2] = '{1, 3};
    int                 m_ptr[2];
    logic [NREQ-1:0]    m_pend[2], m_rv[2], m_ro[2];
    logic [32*NREQ-1:0] m_ry[2];
    logic [31:0]        m_fx1[2], m_fx2[2];
    int                 last_grant[2];

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_grant(input int k);
        for (int s = 0; s < NREQ; s++) begin
            int i;
            i = (m_ptr[k] + s) % NREQ;
            if (d_valid[i] && !m_pend[k][i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        q.delete();
        for (int k = 0; k < 2; k++) begin
            m_ptr[k] = 0; m_pend[k] = '0; m_rv[k] = '0; m_ro[k] = '0;
            m_ry[k] = '0; m_fx1[k] = '0; m_fx2[k] = '0; last_grant[k] = -1;
        end
    endtask

    task automatic drive(input logic [NREQ-1:0] v, input logic [NREQ-1:0] r, input logic [NREQ-1:0] sub,
                         input logic [32*NREQ-1:0] x1, input logic [32*NREQ-1:0] x2);
        @(negedge clk);
        d_valid = v; d_ready = r; d_sub = sub; d_x1 = x1; d_x2 = x2;
        #1;
    endtask

    // Compare every output with the model, then let one clock edge pass and advance the model.
    task automatic step();
        int g[2];
        for (int k = 0; k < 2; k++) begin
            logic [63:0] eg;
            g[k] = exp_grant(k);
            eg = (g[k] < 0) ? 64'd0 : (64'd1 << g[k]);
            check($sformatf("L%0d req_ready", lat[k]), 64'(o_ready[k]), eg);
            check($sformatf("L%0d rsp_valid", lat[k]), 64'(o_rv[k]), 64'(m_rv[k]));
            check($sformatf("L%0d rsp_y", lat[k]), 64'(o_ry[k]), 64'(m_ry[k]));
            check($sformatf("L%0d rsp_ovf", lat[k]), 64'(o_ro[k]), 64'(m_ro[k]));
            check($sformatf("L%0d busy", lat[k]), 64'(o_busy[k]), 64'(|m_pend[k]));
            check($sformatf("L%0d fa_x1", lat[k]), 64'(o_fx1[k]), 64'(m_fx1[k]));
            check($sformatf("L%0d fa_x2", lat[k]), 64'(o_fx2[k]), 64'(m_fx2[k]));
            last_grant[k] = g[k];
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NREQ; i++)
                if (m_rv[k][i] && d_ready[i]) begin
                    m_rv[k][i] = 1'b0;
                    m_pend[k][i] = 1'b0;
                end
        for (int n = q.size() - 1; n >= 0; n--) begin
            item_t it;
            it = q[n];
            it.cnt--;
            if (it.cnt == 0) begin
                m_rv[it.inst][it.owner] = 1'b1;
                m_ry[it.inst][32*it.owner +: 32] = it.y;
                m_ro[it.inst][it.owner] = it.ovf;
                q.delete(n);
            end else begin
                q[n] = it;
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (g[k] >= 0) begin
                item_t it;
                logic [32:0] r;
                m_pend[k][g[k]] = 1'b1;
                m_ptr[k] = (g[k] + 1) % NREQ;
                m_fx1[k] = d_x1[32*g[k] +: 32];
                m_fx2[k] = d_x2[32*g[k] +: 32] ^ {d_sub[g[k]], 31'b0};
                r = fadd_model(m_fx1[k], m_fx2[k]);
                it.inst = k; it.owner = g[k]; it.cnt = lat[k]; it.y = r[31:0]; it.ovf = r[32];
                q.push_back(it);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            drive('0, '1, '0, '0, '0);
            step();
        end
    endtask

    typedef struct {
        int          who;
        logic        sub;
        logic [31:0] x1;
        logic [31:0] x2;
        logic [31:0] exp_fx2;
        logic [31:0] exp_y;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq[$];
        int cnt1;
        logic [31:0] y0;
        bit ok;

        tbl[0] = '{0, 1'b0, 32'h3F800000, 32'h40000000, 32'h40000000, 32'h40400000, 1'b0};
        tbl[1] = '{1, 1'b1, 32'h40400000, 32'h3F800000, 32'hBF800000, 32'h40000000, 1'b0};
        tbl[2] = '{0, 1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1};
        tbl[3] = '{1, 1'b1, 32'h7F800000, 32'h7FC00000, 32'hFFC00000, 32'h7FC00000, 1'b0};

        rst = 1'b1;
        d_valid = '0; d_ready = '0; d_sub = '0; d_x1 = '0; d_x2 = '0;
        model_reset();
        #12;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset L%0d rsp_valid", lat[k]), 64'(o_rv[k]), 64'd0);
            check($sformatf("reset L%0d rsp_y", lat[k]), 64'(o_ry[k]), 64'd0);
            check($sformatf("reset L%0d busy", lat[k]), 64'(o_busy[k]), 64'd0);
            check($sformatf("reset L%0d fa_x1", lat[k]), 64'(o_fx1[k]), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Single operations: same-cycle grant, operands next cycle, latency, result passthrough.
        for (int r = 0; r < 4; r++) begin
            logic [32*NREQ-1:0] x1v, x2v;
            int  seen_c[2];
            x1v = '0; x2v = '0;
            x1v[32*tbl[r].who +: 32] = tbl[r].x1;
            x2v[32*tbl[r].who +: 32] = tbl[r].x2;
            drive(NREQ'(1) << tbl[r].who, '1, NREQ'(tbl[r].sub) << tbl[r].who, x1v, x2v);
            step();
            seen_c[0] = -1; seen_c[1] = -1;
            for (int k = 0; k < 2; k++)
                check($sformatf("vec%0d L%0d granted", r, lat[k]), 64'(last_grant[k]), 64'(tbl[r].who));
            for (int c = 1; c <= 8; c++) begin
                drive('0, '1, '0, x1v, x2v);
                for (int k = 0; k < 2; k++) begin
                    if (c == 1) begin
                        check($sformatf("vec%0d L%0d fa_x1", r, lat[k]), 64'(o_fx1[k]), 64'(tbl[r].x1));
                        check($sformatf("vec%0d L%0d fa_x2", r, lat[k]), 64'(o_fx2[k]), 64'(tbl[r].exp_fx2));
                    end
                    if (seen_c[k] < 0 && o_rv[k][tbl[r].who]) begin
                        seen_c[k] = c;
                        check($sformatf("vec%0d L%0d latency", r, lat[k]), 64'(c), 64'(lat[k] + 1));
                        check($sformatf("vec%0d L%0d rsp_y", r, lat[k]), 64'(o_ry[k][32*tbl[r].who +: 32]), 64'(tbl[r].exp_y));
                        check($sformatf("vec%0d L%0d rsp_ovf", r, lat[k]), 64'(o_ro[k][tbl[r].who]), 64'(tbl[r].exp_ovf));
                    end
                end
                step();
            end
            for (int k = 0; k < 2; k++)
                if (seen_c[k] < 0) check($sformatf("vec%0d L%0d rsp timeout", r, lat[k]), 64'd0, 64'd1);
        end

        // Both requesters continuously valid: strict alternation, never two grants.
        idle(5);
        for (int c = 0; c < 14; c++) begin
            drive('1, '1, 2'b01, {$urandom, $urandom}, {$urandom, $urandom});
            for (int k = 0; k < 2; k++)
                check($sformatf("onehot L%0d", lat[k]), 64'($onehot0(o_ready[k])), 64'd1);
            step();
            if (last_grant[0] >= 0) seq.push_back(last_grant[0]);
        end
        if (seq.size() < 4) check("alternate accept count", 64'(seq.size()), 64'd4);
        else for (int s = 1; s < 4; s++) check("alternate order", 64'(seq[s]), 64'((seq[0] + s) % 2));

        // Requester 0 withholds rsp_ready: result held, no re-grant, requester 1 still served.
        idle(5);
        ok = 1'b0;
        for (int c = 0; c < 10 && !ok; c++) begin
            drive('1, 2'b10, '0, {$urandom, $urandom}, {$urandom, $urandom});
            ok = o_rv[0][0];
            step();
        end
        check("stall rsp_valid0 arrives", 64'(ok), 64'd1);
        y0 = o_ry[0][31:0];
        cnt1 = 0;
        for (int c = 0; c < 6; c++) begin
            drive('1, 2'b10, '0, {$urandom, $urandom}, {$urandom, $urandom});
            check("stall rsp_valid0 held", 64'(o_rv[0][0]), 64'd1);
            check("stall rsp_y0 held", 64'(o_ry[0][31:0]), 64'(y0));
            check("stall no grant req0", 64'(o_ready[0][0]), 64'd0);
            step();
            if (last_grant[0] == 1) cnt1++;
        end
        check("stall req1 served", 64'(cnt1 > 0), 64'd1);
        drive('1, 2'b11, '0, {$urandom, $urandom}, {$urandom, $urandom});
        check("no grant in handshake cycle", 64'(o_ready[0][0]), 64'd0);
        step();
        drive('1, 2'b11, '0, {$urandom, $urandom}, {$urandom, $urandom});
        check("regrant cycle after handshake", 64'(o_ready[0][0]), 64'd1);
        step();

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            logic [32*NREQ-1:0] x1v, x2v;
            logic [NREQ-1:0] rv;
            x1v = {$urandom, $urandom};
            x2v = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) x1v[31:0] = 32'h7F7FFFFF;
            if ($urandom_range(0, 7) == 0) x2v[63:32] = 32'hFFC00000;
            for (int i = 0; i < NREQ; i++) rv[i] = ($urandom_range(0, 3) != 0);
            drive(NREQ'($urandom), rv, NREQ'($urandom), x1v, x2v);
            step();
        end

        // Asynchronous reset with operations in flight.
        idle(5);
        drive('1, '1, '0, {32'h11111111, 32'h22222222}, {32'h33333333, 32'h44444444});
        step();
        @(negedge clk);
        d_valid = '0;
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("async rst L%0d rsp_valid", lat[k]), 64'(o_rv[k]), 64'd0);
            check($sformatf("async rst L%0d busy", lat[k]), 64'(o_busy[k]), 64'd0);
            check($sformatf("async rst L%0d fa_x1", lat[k]), 64'(o_fx1[k]), 64'd0);
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
